uart_rx_frontend: RTL
=====================

// Module: uart_rx_frontend
// PURPOSE
//  Serial receive front-end for the UART block: synchronises the raw rx pin and recovers
//  frames using an oversampled bit clock with a 3-sample majority vote. Delivers one
//  byte at a time over a valid/ready handshake into the UART read buffer.
//  Reports framing errors and overruns as single-cycle pulses. Never blocks the line.
// PARAMETERS
//  CLOCK_FREQ_OVER_BAUD_RATE  16  clk cycles per bit (N); legal range N >= 4
//  UART_FRAME_BITS            8   data bits per frame, LSB first; data_out width
//  PARITY_ODD                 0   0 = even, 1 = odd; used only when UART_RX_PARITY_EN is defined
// PORTS
//  clk           in   1                clock; the only clock
//  rst           in   1                reset; synchronous, active-high
//  rx            in   1                asynchronous serial input; idle high
//  data_out      out  UART_FRAME_BITS  received byte; stable while data_valid=1
//  data_valid    out  1                byte available; held until data_ready
//  data_ready    in   1                consumer accepts on data_valid & data_ready
//  frame_error   out  1                1-cycle pulse: stop bit sampled 0
//  parity_error  out  1                1-cycle pulse: parity mismatch (tied 0 without macro)
//  overrun       out  1                1-cycle pulse: completed byte dropped because holding reg full
//  busy          out  1                1 whenever state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; sync flops=1; data_out=0; data_valid, frame_error, parity_error,
//    overrun, busy=0; counters=0. Reset mid-frame aborts it; partial bits are discarded.
//  - Synchroniser: 2 flops on rx, reset to 1; all logic sees rx_s only (2-cycle lag).
//  - Sample tick: counter 0..N-1 restarts at each state entry. Votes are taken at
//    N/2-1, N/2 and N/2+1. The bit value is the majority of the 3, resolved at N/2+1.
//  - IDLE: rx_s==0 -> START.
//  - START: majority 1 -> IDLE (false start, no pulse). Majority 0 -> DATA at count N-1.
//  - DATA: shift the majority bit in at the MSB and shift right, so the byte is LSB-first.
//    After UART_FRAME_BITS bits, go to PARITY (macro) or STOP at count N-1.
//  - STOP: majority resolved at N/2+1, then act immediately (half-bit early return
//    permits back-to-back frames):
//    1 -> deliver byte (below), go to IDLE.
//    0 -> frame_error pulse, byte discarded, go to BREAK.
//  - BREAK: wait for rx_s==1, then IDLE. A long low line gives exactly one frame_error.
//  - Delivery: in the cycle after the stop decision:
//    data_valid=0, or data_ready=1 in the same cycle -> load data_out, data_valid=1.
//    Otherwise -> overrun pulse; new byte dropped; old byte and data_valid unchanged.
//  - Handshake: data_valid falls the cycle after data_valid & data_ready, unless a
//    simultaneous load occurs. data_out must not change while data_valid=1 and not accepted.
//  - Pulses are never asserted together for one frame. frame_error takes priority over parity_error.
// CONFIGURATION
//  UART_RX_PARITY_EN defined:
//    - PARITY state follows DATA and samples one parity bit.
//    - Expected parity = ^data ^ PARITY_ODD.
//    - On mismatch: parity_error pulse when STOP is accepted; the byte is dropped and not delivered.
//  UART_RX_PARITY_EN undefined:
//    - No PARITY state; the frame is start + UART_FRAME_BITS data + stop.
//    - parity_error is held at 0.
// TESTING (N=16, 8 bits unless stated)
//  - 0xA5 with data_ready=1: data_valid is a 1-cycle pulse with data_out=0xA5, ~9.5*16+3 cycles after the rx fall. No error pulses.
//  - rx low for 4 cycles, then high: returns to IDLE. No data_valid and no pulses; busy drops.
//  - 0x3C with stop=0, then rx held low for 40 bit times, then high: exactly one frame_error.
//    No data_valid. Next 0x55 is received correctly.
//  - 0x11 then 0x22 back-to-back with data_ready=0: data_valid=1 with 0x11 held and exactly one overrun pulse.
//    Then data_ready=1 for 1 cycle: data_valid drops and 0x22 is never delivered.
//  - Macro on, PARITY_ODD=0: send 0x07 with parity bit 0 -> parity_error pulse and no data_valid.
//    Send 0x07 with parity bit 1 -> data_out=0x07.
//  - rst pulsed 1 cycle at data bit 4: all outputs 0 next cycle. A following clean 0xC3 frame is received correctly.

Source files
------------

// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: UART receive front-end.
// Synchronises rx, recovers frames with an N-times oversampled bit clock and a
// 3-sample majority vote, and hands bytes out over a valid/ready handshake.
// Optional feature macro: UART_RX_PARITY_EN (adds a parity bit after the data bits).
module uart_rx_frontend #(
  parameter int CLOCK_FREQ_OVER_BAUD_RATE = 16,
  parameter int UART_FRAME_BITS           = 8,
  parameter int PARITY_ODD                = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rx,
  output logic [UART_FRAME_BITS-1:0] data_out,
  output logic                       data_valid,
  input  logic                       data_ready,
  output logic                       frame_error,
  output logic                       parity_error,
  output logic                       overrun,
  output logic                       busy
);
  localparam int N   = CLOCK_FREQ_OVER_BAUD_RATE;
  localparam int CW  = $clog2(N);
  localparam int BCW = $clog2(UART_FRAME_BITS + 1);
  localparam logic [CW-1:0]  C_V0  = CW'(N/2 - 1);
  localparam logic [CW-1:0]  C_V1  = CW'(N/2);
  localparam logic [CW-1:0]  C_RES = CW'(N/2 + 1);
  localparam logic [CW-1:0]  C_END = CW'(N - 1);
  localparam logic [BCW-1:0] B_ALL = BCW'(UART_FRAME_BITS);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

  state_t                     state, state_d;
  logic                       rx_m, rx_s;
  logic [CW-1:0]              cnt;
  logic [BCW-1:0]             bit_cnt;
  logic [UART_FRAME_BITS-1:0] shreg;
  logic                       v0, v1, maj;
  logic                       at_res, at_end;
  logic                       shift_en, stop_ok, stop_bad;
  logic                       par_bad;

  // two-flop synchroniser, idles high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (rst) {rx_s, rx_m} <= 2'b11;
    else     {rx_s, rx_m} <= {rx_m, rx};
  end

  assign at_res = (cnt == C_RES);
  assign at_end = (cnt == C_END);
  // third vote is the live sample, so the majority resolves at N/2+1
  assign maj    = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);
  assign busy   = (state != S_IDLE);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // next-state and per-cycle control strobes
  always_comb begin
    state_d  = state;
    shift_en = 1'b0;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    case (state)
      S_IDLE:  if (!rx_s) state_d = S_START;
      S_START: begin
        if (at_res && maj) state_d = S_IDLE;   // false start, silently dropped
        else if (at_end)   state_d = S_DATA;
      end
      S_DATA: begin
        shift_en = at_res;
        if (at_end && bit_cnt == B_ALL)
`ifdef UART_RX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (at_end) state_d = S_STOP;
`endif
      S_STOP: begin
        // act half a bit early so a back-to-back start edge is not missed
        if (at_res) begin
          if (maj) begin stop_ok  = 1'b1; state_d = S_IDLE;  end
          else     begin stop_bad = 1'b1; state_d = S_BREAK; end
        end
      end
      S_BREAK: if (rx_s) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // bit timing, vote capture, shifting, delivery and error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      v0          <= 1'b1;
      v1          <= 1'b1;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      overrun     <= 1'b0;
      if (state == S_IDLE || state_d != state || at_end) cnt <= '0;
      else                                               cnt <= cnt + CW'(1);
      if (cnt == C_V0) v0 <= rx_s;
      if (cnt == C_V1) v1 <= rx_s;
      if (state == S_START) bit_cnt <= '0;
      if (shift_en) begin
        shreg   <= {maj, shreg[UART_FRAME_BITS-1:1]};
        bit_cnt <= bit_cnt + BCW'(1);
      end
      if (data_valid && data_ready) data_valid <= 1'b0;
      if (stop_ok && !par_bad) begin
        if (!data_valid || data_ready) begin
          data_out   <= shreg;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;                      // holding reg full: drop new byte
        end
      end
      if (stop_bad) frame_error <= 1'b1;
    end
  end

`ifdef UART_RX_PARITY_EN
  // parity check; a bad frame is only reported once its stop bit is good
  always_ff @(posedge clk) begin
    if (rst) begin
      par_bad      <= 1'b0;
      parity_error <= 1'b0;
    end else begin
      parity_error <= 1'b0;
      if (state == S_START) par_bad <= 1'b0;
      if (state == S_PARITY && at_res)
        par_bad <= maj ^ (^shreg) ^ (PARITY_ODD != 0);
      if (stop_ok && par_bad) parity_error <= 1'b1;
    end
  end
`else
  assign par_bad      = 1'b0;
  assign parity_error = 1'b0;
`endif

endmodule
